// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and sizing constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int DMEM_DATA_W     = 64;
  localparam int DMEM_ALIGN_BITS = 3;
  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_LATENCY    = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous write and registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  assign rdata = rdata_q;
  // storage itself is never reset; only committed writes land here
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  // read register only changes on a read, so it holds the last loaded word
  always_comb rdata_d = re ? mem[idx] : rdata_q;
  // read data register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder; DMEM_PERF_CNT_EN adds rd_count/wr_count
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              access_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d, fault_q, fault_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req, fault, acc, in_idle, ram_we, ram_re;
  logic [IDX_W-1:0]  idx_in, ram_idx;
  logic [DATA_W-1:0] ram_wdata;
  assign req         = memread | memwrite;
  assign idx_in      = addr[IDX_W+DMEM_ALIGN_BITS-1:DMEM_ALIGN_BITS];
  assign fault       = (addr[DMEM_ALIGN_BITS-1:0] != '0)
                     | ((addr >> DMEM_ALIGN_BITS) >= ADDR_W'(DEPTH))
                     | (memread & memwrite);
  assign stall       = rst_n & req & (state_q != DONE);
  assign rdata_valid = (state_q == DONE) & ~fault_q & ~wr_q;
  assign access_err  = (state_q == DONE) & fault_q;
  assign in_idle     = (state_q == IDLE);
  // zero-latency accesses use the live request, otherwise the latched copy
  assign ram_idx     = in_idle ? idx_in : idx_q;
  assign ram_wdata   = in_idle ? wdata : wdata_q;
  assign ram_we      = acc & (in_idle ? memwrite : wr_q);
  assign ram_re      = acc & (in_idle ? memread : ~wr_q);
  // next-state: latch request in IDLE, count wait states in BUSY, report in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        wr_d    = memwrite;
        fault_d = fault;
        idx_d   = idx_in;
        wdata_d = wdata;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = (fault || LATENCY == 0) ? DONE : BUSY;
        acc     = !fault && LATENCY == 0;
      end
      BUSY: begin
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        state_d = (cnt_q == '0) ? DONE : BUSY;
        acc     = (cnt_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and request-latch registers; reset abandons any pending access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (rdata)
  );
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  // count completed good loads and stores; faults are excluded
  always_comb begin
    rd_count_d = rd_count_q + 32'(rdata_valid);
    wr_count_d = wr_count_q + 32'((state_q == DONE) & ~fault_q & wr_q);
  end
  // performance counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
`endif
endmodule
